// File: rtl/reg_ctx_mover_pkg.sv
// ctx_mover_pkg: shared FSM state enum, transfer-mode constants and special register indices
package ctx_mover_pkg;
  typedef enum logic [2:0] {IDLE, SAVE, RD_ISSUE, RD_DRAIN, DONE} state_t;
  localparam logic MODE_SAVE = 1'b0;
  localparam logic MODE_RESTORE = 1'b1;
  localparam logic [3:0] REG_ZERO = 4'hF;
  localparam logic [3:0] REG_PROT = 4'hE;
endpackage

// File: rtl/reg_ctx_mover_if.sv
// reg_ctx_mover_if: control, register-file and data-memory bus of the context mover; master = mover, slave = core/memory side
interface reg_ctx_mover_if #(parameter int W = 8, D = 4, AW = 8);
  logic Start, Mode, Abort, Busy, Done;
  logic [AW-1:0] BaseAddr, memAddr;
  logic [D-1:0] rfSrc, rfWriteReg;
  logic [W-1:0] rfReadData, rfWriteValue, memWriteData, memReadData;
  logic rfRegWrite, memWriteEn, memReadEn;
  modport master(
    input Start, Mode, BaseAddr, Abort, rfReadData, memReadData,
    output Busy, Done, rfSrc, rfRegWrite, rfWriteReg, rfWriteValue, memAddr, memWriteEn, memWriteData, memReadEn
  );
  modport slave(
    output Start, Mode, BaseAddr, Abort, rfReadData, memReadData,
    input Busy, Done, rfSrc, rfRegWrite, rfWriteReg, rfWriteValue, memAddr, memWriteEn, memWriteData, memReadEn
  );
endinterface

// File: rtl/reg_ctx_mover_addr_gen.sv
// ctx_addr_gen: register index counter and base+offset memory address (ports clk, rst_n, load, inc, base -> idx, addr, first, last)
module ctx_addr_gen #(
  parameter int D = 4,
  parameter int AW = 8,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] base,
  output logic [D-1:0]  idx,
  output logic [AW-1:0] addr,
  output logic          first,
  output logic          last
);
  logic [AW-1:0] base_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      base_q <= '0;
    end else if (load) begin
      idx <= D'(FIRST_REG);
      base_q <= base;
    end else if (inc) begin
      idx <= idx + D'(1);
    end
  end
  assign addr = base_q + AW'(idx - D'(FIRST_REG));
  assign first = idx == D'(FIRST_REG);
  assign last = idx == D'(LAST_REG);
endmodule

// File: rtl/reg_ctx_mover.sv
// reg_ctx_mover: context save/restore FSM streaming the register file to/from data memory (ports CLK, Reset_n, bus = ctrl/RF/mem master)
module reg_ctx_mover import ctx_mover_pkg::*; #(
  parameter int W = 8,
  parameter int D = 4,
  parameter int AW = 8,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG = 13
) (
  input logic CLK,
  input logic Reset_n,
  reg_ctx_mover_if.master bus
);
  state_t state, next;
  logic [D-1:0] idx, wr_idx;
  logic [AW-1:0] addr;
  logic first, last, busy, act, rd_wr, load, inc;
  if (FIRST_REG > LAST_REG || LAST_REG >= 2**D) begin : g_bad_range
    $error("reg_ctx_mover: register range FIRST_REG..LAST_REG invalid");
  end
  ctx_addr_gen #(.D(D), .AW(AW), .FIRST_REG(FIRST_REG), .LAST_REG(LAST_REG)) u_addr (
    .clk(CLK), .rst_n(Reset_n), .load(load), .inc(inc), .base(bus.BaseAddr),
    .idx(idx), .addr(addr), .first(first), .last(last)
  );
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    busy = state == SAVE || state == RD_ISSUE || state == RD_DRAIN;
    act = busy && !bus.Abort;
    // the first issue cycle has no read data yet; the drain cycle writes the last register
    rd_wr = (state == RD_ISSUE && !first) || state == RD_DRAIN;
    wr_idx = state == RD_DRAIN ? idx : idx - D'(1);
    load = state == IDLE && bus.Start && !bus.Abort;
    inc = (state == SAVE || state == RD_ISSUE) && !last && !bus.Abort;
    next = state == DONE ? IDLE
         : bus.Abort ? IDLE
         : state == IDLE ? (bus.Start ? (bus.Mode == MODE_RESTORE ? RD_ISSUE : SAVE) : IDLE)
         : state == RD_DRAIN ? DONE
         : !last ? state
         : state == SAVE ? DONE : RD_DRAIN;
    bus.Busy = busy;
    bus.Done = state == DONE;
    bus.rfSrc = state == SAVE ? idx : '0;
    bus.memWriteEn = state == SAVE && act;
    bus.memWriteData = state == SAVE ? bus.rfReadData : W'(0);
    bus.memReadEn = state == RD_ISSUE && act;
    bus.memAddr = busy ? addr : '0;
    bus.rfRegWrite = rd_wr && act && wr_idx != D'(REG_PROT);
    bus.rfWriteReg = rd_wr ? wr_idx : '0;
    bus.rfWriteValue = rd_wr ? bus.memReadData : W'(0);
  end
endmodule

// File: tb/tb_reg_ctx_mover.sv
// tb_reg_ctx_mover: scoreboard bench with cycle-stepped RF/memory models for save, restore, wrap, ignored start, abort and async reset
module tb_reg_ctx_mover;
  import ctx_mover_pkg::*;
  typedef struct packed {logic [7:0] a; logic [7:0] d;} item_t;
  logic CLK, Reset_n;
  reg_ctx_mover_if bus();
  reg_ctx_mover dut(.CLK(CLK), .Reset_n(Reset_n), .bus(bus));
  item_t exp_q[$];
  item_t it;
  logic [7:0] rf[16];
  logic [7:0] mem[256];
  logic [7:0] rd_pend;
  logic last_busy;
  int checks, errors, cyc, t;
  int n_mw, n_rw, first_mw, first_rw, done_cnt, done_cyc, n_busy;
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end
  task automatic clear();
    exp_q.delete();
    n_mw = 0; n_rw = 0; first_mw = -1; first_rw = -1;
    done_cnt = 0; done_cyc = -1; n_busy = 0;
  endtask
  task automatic step(input logic st, input logic md, input logic [7:0] base, input logic ab);
    @(negedge CLK);
    bus.Start = st; bus.Mode = md; bus.BaseAddr = base; bus.Abort = ab;
    bus.memReadData = rd_pend;
    bus.rfReadData = (bus.rfSrc == REG_ZERO) ? 8'h00 : rf[bus.rfSrc];
    #1;
    last_busy = bus.Busy;
    if (bus.Busy) n_busy++;
    if (bus.Done) begin done_cnt++; done_cyc = cyc; end
    if (bus.memReadEn) rd_pend = mem[bus.memAddr];
    if (bus.memWriteEn) begin
      n_mw++;
      if (first_mw < 0) first_mw = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mem_write: unexpected write addr=%h data=%h", bus.memAddr, bus.memWriteData);
      end else begin
        it = exp_q.pop_front();
        if ({bus.memAddr, bus.memWriteData} !== it) begin
          errors++;
          $display("FAIL mem_write: got addr=%h data=%h, expected addr=%h data=%h", bus.memAddr, bus.memWriteData, it.a, it.d);
        end
      end
      mem[bus.memAddr] = bus.memWriteData;
    end
    if (bus.rfRegWrite) begin
      n_rw++;
      if (first_rw < 0) first_rw = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write: unexpected write reg=%h val=%h", bus.rfWriteReg, bus.rfWriteValue);
      end else begin
        it = exp_q.pop_front();
        if ({4'h0, bus.rfWriteReg, bus.rfWriteValue} !== it) begin
          errors++;
          $display("FAIL rf_write: got reg=%h val=%h, expected reg=%h val=%h", bus.rfWriteReg, bus.rfWriteValue, it.a, it.d);
        end
      end
      if (bus.rfWriteReg != REG_PROT) rf[bus.rfWriteReg] = bus.rfWriteValue;
    end
    cyc++;
  endtask
  task automatic wait_done();
    for (int k = 0; k < 40 && done_cnt == 0; k++) step(0, MODE_SAVE, 8'h00, 0);
  endtask
  task automatic test_reset();
    Reset_n = 0;
    bus.Start = 0; bus.Mode = 0; bus.BaseAddr = 0; bus.Abort = 0;
    bus.rfReadData = 0; bus.memReadData = 0; rd_pend = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    #1;
    checks++;
    if ({bus.Busy, bus.Done, bus.rfRegWrite, bus.memWriteEn, bus.memReadEn} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00000", {bus.Busy, bus.Done, bus.rfRegWrite, bus.memWriteEn, bus.memReadEn});
    end
    checks++;
    if ({bus.memAddr, bus.rfSrc, bus.rfWriteReg, bus.rfWriteValue, bus.memWriteData} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {bus.memAddr, bus.rfSrc, bus.rfWriteReg, bus.rfWriteValue, bus.memWriteData});
    end
    repeat (2) @(negedge CLK);
    Reset_n = 1;
  endtask
  task automatic test_abort_idle();
    clear();
    step(1, MODE_SAVE, 8'h40, 1);
    repeat (4) step(0, MODE_SAVE, 8'h00, 0);
    checks++;
    if (n_busy != 0 || n_mw != 0) begin
      errors++;
      $display("FAIL abort_idle: got busy_cycles=%0d writes=%0d expected 0/0", n_busy, n_mw);
    end
  endtask
  task automatic test_save();
    for (int i = 0; i < 14; i++) rf[i] = 8'(8'h10 + i);
    rf[14] = 8'hEE;
    clear();
    for (int i = 0; i < 14; i++) exp_q.push_back({8'(8'h40 + i), 8'(8'h10 + i)});
    t = cyc;
    step(1, MODE_SAVE, 8'h40, 0);
    wait_done();
    step(0, MODE_SAVE, 8'h00, 0);
    checks++;
    if (n_mw != 14) begin errors++; $display("FAIL save_count: got %0d expected 14", n_mw); end
    checks++;
    if (first_mw != t + 1) begin errors++; $display("FAIL save_first: got %0d expected %0d", first_mw - t, 1); end
    checks++;
    if (done_cyc != t + 15) begin errors++; $display("FAIL save_done: got t+%0d expected t+15", done_cyc - t); end
    checks++;
    if (done_cnt != 1 || last_busy !== 1'b0) begin
      errors++;
      $display("FAIL save_end: got done_cnt=%0d busy=%b expected 1/0", done_cnt, last_busy);
    end
    checks++;
    if (n_busy != 14 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL save_busy: got busy_cycles=%0d left=%0d expected 14/0", n_busy, exp_q.size());
    end
    checks++;
    if (mem[8'h4D] !== 8'h1D) begin errors++; $display("FAIL save_mem: got %h expected 1d", mem[8'h4D]); end
  endtask
  task automatic test_restore();
    for (int i = 0; i < 14; i++) begin
      mem[8'h80 + i] = 8'(8'hA0 + i);
      rf[i] = 8'h55;
    end
    clear();
    for (int i = 0; i < 14; i++) exp_q.push_back({8'(i), 8'(8'hA0 + i)});
    t = cyc;
    step(1, MODE_RESTORE, 8'h80, 0);
    wait_done();
    step(0, MODE_SAVE, 8'h00, 0);
    checks++;
    if (n_rw != 14 || n_mw != 0) begin
      errors++;
      $display("FAIL restore_count: got rf=%0d mem=%0d expected 14/0", n_rw, n_mw);
    end
    checks++;
    if (first_rw != t + 2) begin errors++; $display("FAIL restore_first: got t+%0d expected t+2", first_rw - t); end
    checks++;
    if (done_cyc != t + 16) begin errors++; $display("FAIL restore_done: got t+%0d expected t+16", done_cyc - t); end
    checks++;
    if (rf[14] !== 8'hEE || rf[13] !== 8'hAD || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restore_regs: got r14=%h r13=%h left=%0d expected ee/ad/0", rf[14], rf[13], exp_q.size());
    end
    checks++;
    if (n_busy != 15) begin errors++; $display("FAIL restore_busy: got %0d expected 15", n_busy); end
  endtask
  task automatic test_wrap();
    clear();
    for (int i = 0; i < 14; i++) exp_q.push_back({8'(8'hFA + i), rf[i]});
    t = cyc;
    step(1, MODE_SAVE, 8'hFA, 0);
    wait_done();
    checks++;
    if (n_mw != 14 || done_cyc != t + 15) begin
      errors++;
      $display("FAIL wrap_run: got writes=%0d done=t+%0d expected 14/t+15", n_mw, done_cyc - t);
    end
    checks++;
    if (mem[8'h07] !== rf[13] || mem[8'hFF] !== rf[5]) begin
      errors++;
      $display("FAIL wrap_mem: got %h/%h expected %h/%h", mem[8'h07], mem[8'hFF], rf[13], rf[5]);
    end
  endtask
  task automatic test_start_ignored();
    clear();
    for (int i = 0; i < 14; i++) exp_q.push_back({8'(8'h20 + i), rf[i]});
    t = cyc;
    step(1, MODE_SAVE, 8'h20, 0);
    for (int k = 1; k <= 14; k++) step(k == 6, MODE_RESTORE, 8'h90, 0);
    step(1, MODE_RESTORE, 8'h90, 0);
    repeat (10) step(0, MODE_SAVE, 8'h00, 0);
    checks++;
    if (n_mw != 14 || n_rw != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_writes: got mem=%0d rf=%0d left=%0d expected 14/0/0", n_mw, n_rw, exp_q.size());
    end
    checks++;
    if (done_cnt != 1 || done_cyc != t + 15) begin
      errors++;
      $display("FAIL ignore_done: got cnt=%0d at t+%0d expected 1 at t+15", done_cnt, done_cyc - t);
    end
    checks++;
    if (n_busy != 14) begin errors++; $display("FAIL ignore_busy: got %0d expected 14", n_busy); end
  endtask
  task automatic test_abort();
    for (int i = 0; i < 14; i++) begin
      mem[8'hC0 + i] = 8'(8'h60 + i);
      rf[i] = 8'h33;
    end
    clear();
    for (int i = 0; i < 5; i++) exp_q.push_back({8'(i), 8'(8'h60 + i)});
    step(1, MODE_RESTORE, 8'hC0, 0);
    repeat (6) step(0, MODE_SAVE, 8'h00, 0);
    step(0, MODE_SAVE, 8'h00, 1);
    step(0, MODE_SAVE, 8'h00, 0);
    checks++;
    if (last_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", last_busy); end
    repeat (20) step(0, MODE_SAVE, 8'h00, 0);
    checks++;
    if (done_cnt != 0 || n_rw != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_writes: got done=%0d rf=%0d left=%0d expected 0/5/0", done_cnt, n_rw, exp_q.size());
    end
    checks++;
    if (rf[4] !== 8'h64 || rf[5] !== 8'h33) begin
      errors++;
      $display("FAIL abort_regs: got r4=%h r5=%h expected 64/33", rf[4], rf[5]);
    end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 14; i++) rf[i] = 8'(8'hC0 + i);
    clear();
    for (int i = 0; i < 14; i++) exp_q.push_back({8'(8'h40 + i), rf[i]});
    step(1, MODE_SAVE, 8'h40, 0);
    repeat (5) step(0, MODE_SAVE, 8'h00, 0);
    @(posedge CLK);
    #2;
    Reset_n = 0;
    #1;
    checks++;
    if ({bus.Busy, bus.Done, bus.memWriteEn, bus.memAddr, bus.rfSrc, bus.memWriteData} !== 23'h0) begin
      errors++;
      $display("FAIL areset_out: got busy=%b we=%b addr=%h src=%h expected all 0", bus.Busy, bus.memWriteEn, bus.memAddr, bus.rfSrc);
    end
    checks++;
    if (n_mw != 5) begin errors++; $display("FAIL areset_partial: got %0d expected 5", n_mw); end
    @(negedge CLK);
    @(negedge CLK);
    Reset_n = 1;
    clear();
    for (int i = 0; i < 14; i++) exp_q.push_back({8'(8'h50 + i), rf[i]});
    t = cyc;
    step(1, MODE_SAVE, 8'h50, 0);
    wait_done();
    checks++;
    if (n_mw != 14 || done_cyc != t + 15 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL areset_rerun: got writes=%0d done=t+%0d left=%0d expected 14/t+15/0", n_mw, done_cyc - t, exp_q.size());
    end
  endtask
  initial begin
    checks = 0; errors = 0; cyc = 0;
    clear();
    test_reset();
    test_abort_idle();
    test_save();
    test_restore();
    test_wrap();
    test_start_ignored();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
